// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider.
// One result bit per CALC cycle, sign fix-up in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             IsMul,
  input  logic             IsDiv,
  input  logic [2:0]       MulFunct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_mul_q;
  logic               long_q;
  logic               neg_q;
  logic               rneg_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH:0]     rem_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic               dbz_q;

  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    accept = Start & (IsMul | IsDiv);
    a_neg  = MulFunct[1] & SrcA[WIDTH-1];
    b_neg  = MulFunct[1] & SrcB[WIDTH-1];
    a_mag  = a_neg ? -SrcA : SrcA;
    b_mag  = b_neg ? -SrcB : SrcB;
  end

  // Multiplier sits in the low half of acc and shifts out LSB first.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      mul_sum = mul_sum + {1'b0, opnd_q};
    end
    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    shl   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff  = shl - {1'b0, opnd_q};
    rem_d = diff[WIDTH] ? shl : diff;
    quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -quo_q : quo_q;
    rem_fix  = rneg_q ? -rem_q[WIDTH-1:0]
                      : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      long_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q   <= 1'b1;
            is_mul_q <= IsMul;
            long_q   <= IsMul & MulFunct[2];
            cnt_q    <= '0;
            if (IsMul) begin
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= 1'b0;
              opnd_q  <= a_mag;
              acc_q   <= {{WIDTH{1'b0}}, b_mag};
              state_q <= CALC;
            end else if (SrcB == '0) begin
              lo_q    <= '0;
              hi_q    <= SrcA;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              opnd_q  <= b_mag;
              quo_q   <= a_mag;
              rem_q   <= '0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (is_mul_q) begin
            acc_q <= acc_d;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (is_mul_q) begin
            lo_q <= prod_fix[WIDTH-1:0];
            hi_q <= long_q ? prod_fix[2*WIDTH-1:WIDTH]
                           : '0;
          end else begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign ResultLo  = lo_q;
  assign ResultHi  = hi_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random ops
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        IsMul;
  logic        IsDiv;
  logic [2:0]  MulFunct;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] ResultLo;
  logic [31:0] ResultHi;
  logic        DivByZero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .IsMul     (IsMul),
    .IsDiv     (IsDiv),
    .MulFunct  (MulFunct),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .Done      (Done),
    .ResultLo  (ResultLo),
    .ResultHi  (ResultHi),
    .DivByZero (DivByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic.
  task automatic model(input bit mul,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [31:0] lo,
                       output logic [31:0] hi,
                       output logic dbz,
                       output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    dbz = 1'b0;
    lat = 33;
    if (f[1]) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    if (mul) begin
      p  = sa * sb;
      lo = p[31:0];
      hi = f[2] ? p[63:32] : 32'h0;
    end else if (b == 32'h0) begin
      lo  = 32'h0;
      hi  = a;
      dbz = 1'b1;
      lat = 0;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  task automatic run_op(input string tag,
                        input bit mul,
                        input bit div,
                        input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit inject);
    logic [31:0] elo, ehi;
    logic edbz;
    int elat;
    int n;
    bit busy_ok;
    model(mul, f, a, b, elo, ehi, edbz, elat);
    @(negedge clk);
    Start    = 1'b1;
    IsMul    = mul;
    IsDiv    = div;
    MulFunct = f;
    SrcA     = a;
    SrcB     = b;
    @(negedge clk);
    Start = 1'b0;
    SrcA  = $urandom;
    SrcB  = $urandom;
    n = 0;
    busy_ok = 1'b1;
    while (n < 200 && !Done) begin
      if (!Busy) busy_ok = 1'b0;
      if (inject && (n == 5 || n == 20)) begin
        Start    = 1'b1;
        IsMul    = 1'b1;
        MulFunct = 3'b100;
        SrcA     = $urandom;
        SrcB     = $urandom;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    Start = 1'b0;
    chk({tag, ".lat"}, 64'(n), 64'(elat));
    chk({tag, ".busy"}, {63'b0, busy_ok & Busy}, 64'd1);
    chk({tag, ".lo"}, {32'b0, ResultLo}, {32'b0, elo});
    chk({tag, ".hi"}, {32'b0, ResultHi}, {32'b0, ehi});
    chk({tag, ".dbz"}, {63'b0, DivByZero}, {63'b0, edbz});
    @(negedge clk);
    chk({tag, ".pulse"}, {62'b0, Done, Busy}, 64'd0);
    chk({tag, ".hold"}, {ResultHi, ResultLo}, {ehi, elo});
  endtask

  initial begin
    bit m, d, seen;
    logic [31:0] ra, rb;
    reset    = 1'b0;
    Start    = 1'b0;
    IsMul    = 1'b0;
    IsDiv    = 1'b0;
    MulFunct = 3'b000;
    SrcA     = '0;
    SrcB     = '0;
    repeat (2) @(negedge clk);
    chk("rst.ctl", {61'b0, Busy, Done, DivByZero}, 64'd0);
    chk("rst.res", {ResultHi, ResultLo}, 64'd0);
    reset = 1'b1;

    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("noop", {63'b0, Busy}, 64'd0);

    run_op("mul", 1, 0, 3'b000, 32'd7, 32'hFFFFFFFD, 0);
    run_op("umull", 1, 0, 3'b100,
           32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("smull", 1, 0, 3'b110,
           32'h80000000, 32'h80000000, 0);
    run_op("udiv", 0, 1, 3'b000, 32'd100, 32'd7, 0);
    run_op("sdiv", 0, 1, 3'b010,
           32'hFFFFFF9C, 32'd7, 0);
    run_op("sovf", 0, 1, 3'b010,
           32'h80000000, 32'hFFFFFFFF, 0);
    run_op("dbz", 0, 1, 3'b000, 32'd5, 32'd0, 0);
    run_op("after", 0, 1, 3'b000, 32'd9, 32'd3, 0);
    run_op("both", 1, 1, 3'b001, 32'd12, 32'd5, 0);
    run_op("inj", 1, 0, 3'b110,
           32'hFFFF1234, 32'h00C0FFEE, 1);

    @(negedge clk);
    Start = 1'b1;
    IsMul = 1'b0;
    IsDiv = 1'b1;
    MulFunct = 3'b000;
    SrcA = 32'd1000;
    SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst.ctl", {61'b0, Busy, Done, DivByZero}, 64'd0);
    chk("arst.res", {ResultHi, ResultLo}, 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    chk("arst.nodone", {63'b0, seen}, 64'd0);
    run_op("post", 1, 0, 3'b000, 32'd6, 32'd7, 0);

    for (int i = 0; i < 24; i++) begin
      m  = 1'($urandom % 2);
      d  = !m || ($urandom % 4 == 0);
      ra = $urandom;
      rb = ($urandom % 6 == 0) ? 32'h0 : $urandom;
      if ($urandom % 3 == 0) rb = rb >> ($urandom % 28);
      run_op("rnd", m, d, 3'($urandom), ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
